// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a 64 x 32-bit register array.
// Adds programmable data-phase wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic        HMASTLOCK,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] LP_WLOAD =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [7:0]  r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic [31:0] r_mem [64];

    logic        w_ready_state;
    logic        w_accept;
    logic        w_illegal;
    logic        w_wr_en;
    logic [3:0]  w_be;

    wire w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Only states that drive HREADYOUT high may open a new address phase.
    assign w_ready_state = (r_state == S_IDLE) |
                           (r_state == S_DATA) |
                           (r_state == S_ERR2);
    assign w_accept  = w_ready_state & HSEL & HREADY & HTRANS[1];
    assign w_illegal = (HSIZE > 3'd2) |
                       ((HSIZE == 3'd1) & HADDR[0]) |
                       ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign w_wr_en   = (r_state == S_DATA) & r_write;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!w_accept) begin
                    w_next = S_IDLE;
                end else if (w_illegal) begin
                    w_next = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_DATA;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        unique case (r_state)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: HRDATA = r_mem[r_addr[7:2]];
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_cnt <= 3'd0;
        end else if (w_accept && !w_illegal) begin
            r_cnt <= LP_WLOAD;
        end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_addr  <= 8'h00;
            r_size  <= 2'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= HADDR;
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
        end
    end

    always_comb begin
        w_be = 4'b0000;
        unique case (r_size)
            2'd0:    w_be = 4'b0001 << r_addr[1:0];
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Little-endian lane writes commit on the edge that ends the DATA cycle.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            for (int i = 0; i < 64; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_addr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 2, 3 wait states) checked
// every cycle against a transfer-level model, plus directed literal checks.
module tb_ahb_sram_slave;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hsel   [NI];
    logic [7:0]  haddr  [NI];
    logic [31:0] hwdata [NI];
    logic        hwrite [NI];
    logic [2:0]  hsize  [NI];
    logic [1:0]  htrans [NI];
    wire         hreadyout [NI];
    wire         hresp     [NI];
    wire  [31:0] hrdata    [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_sram_slave #(
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .HCLK      (clk),
            .HRESET    (rst_n),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HTRANS    (htrans[g]),
            .HREADY    (hreadyout[g]),
            .HMASTLOCK (1'b0),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g])
        );
    end

    // Transfer-level model: one outstanding transfer per instance.
    bit          m_pend [NI];
    bit          m_err  [NI];
    bit          m_wr   [NI];
    int          m_ph   [NI];
    int          m_rem  [NI];
    logic [7:0]  m_addr [NI];
    logic [2:0]  m_size [NI];
    logic [31:0] mem    [NI][64];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic e_rdy(input int k);
        if (!m_pend[k]) return 1'b1;
        if (m_err[k]) return m_ph[k] == 2;
        return m_rem[k] == 0;
    endfunction

    function automatic logic e_resp(input int k);
        return m_pend[k] && m_err[k];
    endfunction

    function automatic logic [31:0] e_rdata(input int k);
        if (m_pend[k] && !m_err[k] && m_rem[k] == 0)
            return mem[k][m_addr[k][7:2]];
        return 32'h0;
    endfunction

    function automatic bit illegal(input logic [7:0] a, input logic [2:0] s);
        if (s > 3) return 1'b1;
        if (s == 3'd3) return 1'b1;
        if (s == 3'd1 && a[0]) return 1'b1;
        if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_pend[k] = 0;
            m_err[k]  = 0;
            m_wr[k]   = 0;
            m_ph[k]   = 0;
            m_rem[k]  = 0;
            m_addr[k] = 8'h0;
            m_size[k] = 3'd0;
            for (int w = 0; w < 64; w++) mem[k][w] = 32'h0;
        end
    endtask

    task automatic model_step(input int k);
        logic rdy;
        int   lane;
        int   wi;
        bit   sel;
        rdy = e_rdy(k);
        if (m_pend[k]) begin
            if (m_err[k]) begin
                if (m_ph[k] == 1) m_ph[k] = 2;
                else m_pend[k] = 0;
            end else if (m_rem[k] > 0) begin
                m_rem[k] = m_rem[k] - 1;
            end else begin
                if (m_wr[k]) begin
                    wi = int'(m_addr[k]) / 4;
                    for (int b = 0; b < 4; b++) begin
                        lane = int'(m_addr[k]) % 4;
                        sel = (m_size[k] == 3'd2) ||
                              (m_size[k] == 3'd1 && b / 2 == lane / 2) ||
                              (m_size[k] == 3'd0 && b == lane);
                        if (sel) mem[k][wi][8*b +: 8] = hwdata[k][8*b +: 8];
                    end
                end
                m_pend[k] = 0;
            end
        end
        if (rdy && hsel[k] && htrans[k][1]) begin
            m_pend[k] = 1;
            m_err[k]  = illegal(haddr[k], hsize[k]);
            m_ph[k]   = 1;
            m_rem[k]  = ws_of(k);
            m_addr[k] = haddr[k];
            m_size[k] = hsize[k];
            m_wr[k]   = hwrite[k];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int k = 0; k < NI; k++) model_step(k);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("cyc_ready[%0d]", k),
                    32'(hreadyout[k]), 32'(e_rdy(k)));
                chk($sformatf("cyc_resp[%0d]", k),
                    32'(hresp[k]), 32'(e_resp(k)));
                chk($sformatf("cyc_rdata[%0d]", k), hrdata[k], e_rdata(k));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            hsel[k]   = 1'b0;
            haddr[k]  = 8'h0;
            hwdata[k] = 32'h0;
            hwrite[k] = 1'b0;
            hsize[k]  = 3'd0;
            htrans[k] = 2'd0;
        end
    endtask

    task automatic addr_ph(input int k, input logic [7:0] a,
                           input logic [2:0] sz, input logic wr,
                           input logic [1:0] tr);
        hsel[k]   = 1'b1;
        haddr[k]  = a;
        hsize[k]  = sz;
        hwrite[k] = wr;
        htrans[k] = tr;
    endtask

    task automatic do_xfer(input int k, input logic [7:0] a,
                           input logic [2:0] sz, input logic wr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic rsp, output int lows);
        bit done;
        addr_ph(k, a, sz, wr, 2'd2);
        cyc();
        hsel[k]   = 1'b0;
        htrans[k] = 2'd0;
        hwdata[k] = wd;
        lows = 0;
        rd   = 32'h0;
        rsp  = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (hreadyout[k]) begin
                rd   = hrdata[k];
                rsp  = hresp[k];
                done = 1;
            end else begin
                lows++;
            end
        end
        chk("xfer_done", 32'(done), 32'd1);
        cyc();
    endtask

    logic [31:0] rd;
    logic        rsp;
    int          lows;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle_all();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(hreadyout[k]), 32'd1);
            chk("rst_resp", 32'(hresp[k]), 32'd0);
            chk("rst_rdata", hrdata[k], 32'h0);
        end
        #2 rst_n = 1'b1;
        cyc();

        do_xfer(0, 8'h3C, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("rd3c_data", rd, 32'h0);
        chk("rd3c_resp", 32'(rsp), 32'd0);
        chk("rd3c_lows", 32'(lows), 32'd0);

        lows = 0;
        addr_ph(0, 8'h10, 3'd2, 1'b1, 2'd2);
        cyc();
        addr_ph(0, 8'h10, 3'd2, 1'b0, 2'd2);
        hwdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        if (!hreadyout[0]) lows++;
        cyc();
        hsel[0]   = 1'b0;
        htrans[0] = 2'd0;
        hwdata[0] = 32'h0;
        @(negedge clk);
        if (!hreadyout[0]) lows++;
        rd = hrdata[0];
        cyc();
        chk("b2b_rdata", rd, 32'hDEADBEEF);
        chk("b2b_lows", 32'(lows), 32'd0);

        do_xfer(0, 8'h21, 3'd0, 1'b1, 32'h0000AA00, rd, rsp, lows);
        do_xfer(0, 8'h22, 3'd1, 1'b1, 32'h12340000, rd, rsp, lows);
        do_xfer(0, 8'h20, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("lanes_word20", rd, 32'h1234AA00);

        do_xfer(0, 8'h05, 3'd1, 1'b1, 32'hFFFFFFFF, rd, rsp, lows);
        chk("err05_resp", 32'(rsp), 32'd1);
        chk("err05_lows", 32'(lows), 32'd1);
        do_xfer(0, 8'h04, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("err05_readback", rd, 32'h0);

        do_xfer(0, 8'h08, 3'd2, 1'b1, 32'h11223344, rd, rsp, lows);
        do_xfer(0, 8'h08, 3'd3, 1'b1, 32'hFFFFFFFF, rd, rsp, lows);
        chk("err08_resp", 32'(rsp), 32'd1);
        chk("err08_lows", 32'(lows), 32'd1);
        do_xfer(0, 8'h08, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("err08_readback", rd, 32'h11223344);

        do_xfer(2, 8'h40, 3'd2, 1'b1, 32'hCAFEF00D, rd, rsp, lows);
        chk("ws3_wr_lows", 32'(lows), 32'd3);
        do_xfer(2, 8'h40, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("ws3_rd_lows", 32'(lows), 32'd3);
        chk("ws3_rd_data", rd, 32'hCAFEF00D);
        chk("ws3_rd_resp", 32'(rsp), 32'd0);

        addr_ph(2, 8'h44, 3'd2, 1'b0, 2'd1);
        cyc();
        addr_ph(2, 8'h44, 3'd2, 1'b0, 2'd0);
        @(negedge clk);
        chk("busy_ready", 32'(hreadyout[2]), 32'd1);
        chk("busy_resp", 32'(hresp[2]), 32'd0);
        cyc();
        idle_all();
        @(negedge clk);
        chk("idle_ready", 32'(hreadyout[2]), 32'd1);
        chk("idle_resp", 32'(hresp[2]), 32'd0);
        cyc();

        addr_ph(1, 8'h30, 3'd2, 1'b1, 2'd2);
        cyc();
        hsel[1]   = 1'b0;
        htrans[1] = 2'd0;
        hwdata[1] = 32'h55555555;
        @(negedge clk);
        chk("ws2_first_wait", 32'(hreadyout[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(hreadyout[1]), 32'd1);
        chk("midrst_resp", 32'(hresp[1]), 32'd0);
        chk("midrst_rdata", hrdata[1], 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        hwdata[1] = 32'h0;
        cyc();
        do_xfer(1, 8'h30, 3'd2, 1'b0, 32'h0, rd, rsp, lows);
        chk("midrst_readback", rd, 32'h0);
        chk("ws2_rd_lows", 32'(lows), 32'd2);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave memory that consumes the bus signals carried by the team's AHB interface (DUT-side signal set) and services them from a 64 x 32-bit internal SRAM array. It sits directly downstream of the AHB driver/interconnect. It returns read data, HREADYOUT and HRESP to the master, and the monitor observes those responses. It supports byte/halfword/word transfers, programmable wait states, and a two-cycle ERROR response on illegal transfers.

## Interface
- WAIT_STATES, 0, data-phase wait cycles inserted per accepted transfer (0..7)
- HCLK  input  1  clock; all state updates on rising edge
- HRESET  input  1  asynchronous, active-low reset (asserted when 0)
- HSEL  input  1  slave select
- HADDR  input  8  byte address (256 B space = 64 words)
- HWDATA  input  32  write data, valid in data phase
- HRDATA  output  32  read data, valid in data phase when HREADYOUT=1
- HWRITE  input  1  1=write, 0=read
- HSIZE  input  3  0=byte, 1=halfword, 2=word; >2 illegal
- HBURST  input  3  accepted, ignored (address supplied every beat)
- HPROT  input  4  accepted, ignored
- HTRANS  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- HREADY  input  1  bus-level ready; address phase sampled only when 1
- HMASTLOCK  input  1  accepted, ignored
- HREADYOUT  output  1  slave ready / data-phase completion
- HRESP  output  1  0=OKAY, 1=ERROR

## Operation
- Address-phase accept: HSEL & HREADY & HTRANS[1] on a rising edge.
  - Registers addr_q, size_q, write_q.
  - Moves the FSM out of IDLE.
- IDLE, BUSY, or unselected beats receive a zero-wait OKAY.
- Illegal transfer:
  - HSIZE>2.
  - HSIZE=1 with HADDR[0]=1.
  - HSIZE=2 with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept goes to WAIT if WAIT_STATES>0, else DATA. Illegal accept goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The down-counter loads WAIT_STATES-1 on entry. Goes to DATA when the count reaches 0.
  - DATA: HREADYOUT=1, HRESP=0. Final data-phase cycle. A new accept in this cycle re-enters WAIT/DATA/ERR1 (back-to-back, pipelined). No accept returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept in this cycle is handled exactly as from IDLE. Otherwise goes to IDLE.
- Write: performed at the rising edge ending the DATA cycle, little-endian lanes.
  - Byte: lane addr_q[1:0].
  - Halfword: lanes {addr_q[1],0} and {addr_q[1],1}.
  - Word: all 4 lanes.
  - Unselected lanes are unchanged.
- Read: HRDATA = full word mem[addr_q[7:2]] in DATA state, else 32'h0. The master extracts lanes.
- ERROR transfers never modify memory. HRDATA=0 in ERR1/ERR2.
- Read-after-write to the same address in consecutive transfers returns the new data, because the write commits before the read's DATA cycle.

## Timing
- Reset (HRESET=0, async):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM in IDLE, wait counter 0.
  - All 64 memory words cleared to 0.
- Reset asserted mid-transfer aborts it immediately, with no write. Outputs take reset values within the same cycle.
- Latency, accept edge to completing edge: WAIT_STATES+1 cycles for OKAY; 2 cycles for ERROR.
- HREADYOUT low cycles per OKAY transfer: exactly WAIT_STATES. Per ERROR: exactly 1 (ERR1).
- HWDATA is sampled only at the completing edge (DATA, HREADYOUT=1).
- With HREADY=0, HSEL/HTRANS/HADDR are ignored. In single-slave benches HREADY is tied to HREADYOUT.
- Maximum throughput: one transfer per cycle when WAIT_STATES=0.
- Wait-counter width: 3 bits. WAIT_STATES>7 is unsupported.

## Test plan
- Reset, then check outputs; read word 0x3C (NONSEQ, HSIZE=2) -> HREADYOUT=1, HRESP=0, HRDATA=0x00000000.
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then immediately read 0x10 back-to-back -> read data phase HRDATA=0xDEADBEEF, HREADYOUT never low.
- Byte write 0xAA to 0x21, then halfword write 0x1234 to 0x22 over initial word 0 -> word read at 0x20 returns 0x1234AA00.
- Halfword access at 0x05, and HSIZE=3 at 0x08 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); the target words are unchanged on readback.
- WAIT_STATES=3: word read of 0x40 -> exactly 3 cycles HREADYOUT=0 then data cycle. The interleaved BUSY and IDLE beats get a zero-wait OKAY.
- WAIT_STATES=2: start a write of 0x55555555 to 0x30, assert HRESET in the first wait cycle -> outputs reset, and word 0x30 reads 0 after release.
